// File: rtl/rs_issue.sv
// Reservation station with tag wakeup and MSB-priority select.
// One dispatch and one issue per cycle; selection from registered state.
module rs_issue #(
   parameter int RS_SIZE = 8,
   parameter int TAG_W   = 6,
   parameter int PAY_W   = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         dispatch_valid,
   output logic                         dispatch_ready,
   input  logic [TAG_W-1:0]             dispatch_src1,
   input  logic [TAG_W-1:0]             dispatch_src2,
   input  logic                         dispatch_rdy1,
   input  logic                         dispatch_rdy2,
   input  logic [TAG_W-1:0]             dispatch_dest,
   input  logic [PAY_W-1:0]             dispatch_payload,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [TAG_W-1:0]             issue_dest,
   output logic [PAY_W-1:0]             issue_payload,
   output logic [$clog2(RS_SIZE):0]     free_count
);

   localparam int IW = $clog2(RS_SIZE);
   localparam int CW = IW + 1;

   logic [RS_SIZE-1:0] r_valid;
   logic [RS_SIZE-1:0] r_rdy1;
   logic [RS_SIZE-1:0] r_rdy2;
   logic [TAG_W-1:0]   r_src1 [RS_SIZE];
   logic [TAG_W-1:0]   r_src2 [RS_SIZE];
   logic [TAG_W-1:0]   r_dest [RS_SIZE];
   logic [PAY_W-1:0]   r_pay  [RS_SIZE];

   logic [RS_SIZE-1:0] w_elig;
   logic [IW-1:0]      w_alloc_idx;
   logic               w_alloc_any;
   logic [IW-1:0]      w_iss_idx;
   logic               w_iss_any;
   logic [CW-1:0]      w_used;
   logic               w_disp_fire;
   logic               w_iss_fire;
   logic               w_byp1;
   logic               w_byp2;

   assign w_elig = r_valid & r_rdy1 & r_rdy2;

   // Highest-index free slot, highest-index eligible slot, occupancy count
   always_comb begin
      w_alloc_idx = '0;
      w_alloc_any = 1'b0;
      w_iss_idx   = '0;
      w_iss_any   = 1'b0;
      w_used      = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!r_valid[i]) begin
            w_alloc_idx = IW'(i);
            w_alloc_any = 1'b1;
         end
         if (w_elig[i]) begin
            w_iss_idx = IW'(i);
            w_iss_any = 1'b1;
         end
         w_used = w_used + CW'(r_valid[i]);
      end
   end

   assign dispatch_ready = w_alloc_any;
   assign issue_valid    = w_iss_any;
   assign issue_dest     = w_iss_any ? r_dest[w_iss_idx] : '0;
   assign issue_payload  = w_iss_any ? r_pay[w_iss_idx] : '0;
   assign free_count     = CW'(RS_SIZE) - w_used;

   assign w_disp_fire = dispatch_valid && w_alloc_any;
   assign w_iss_fire  = w_iss_any && issue_ready;
   assign w_byp1      = cdb_valid && (dispatch_src1 == cdb_tag);
   assign w_byp2      = cdb_valid && (dispatch_src2 == cdb_tag);

   // Entry state: wakeup, issue clear, dispatch write (slots never collide)
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            r_src1[i] <= '0;
            r_src2[i] <= '0;
            r_dest[i] <= '0;
            r_pay[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (cdb_valid && r_valid[i] && (r_src1[i] == cdb_tag))
               r_rdy1[i] <= 1'b1;
            if (cdb_valid && r_valid[i] && (r_src2[i] == cdb_tag))
               r_rdy2[i] <= 1'b1;
         end
         if (w_iss_fire) begin
            r_valid[w_iss_idx] <= 1'b0;
            r_rdy1[w_iss_idx]  <= 1'b0;
            r_rdy2[w_iss_idx]  <= 1'b0;
         end
         if (w_disp_fire) begin
            r_valid[w_alloc_idx] <= 1'b1;
            r_src1[w_alloc_idx]  <= dispatch_src1;
            r_src2[w_alloc_idx]  <= dispatch_src2;
            r_rdy1[w_alloc_idx]  <= dispatch_rdy1 | w_byp1;
            r_rdy2[w_alloc_idx]  <= dispatch_rdy2 | w_byp2;
            r_dest[w_alloc_idx]  <= dispatch_dest;
            r_pay[w_alloc_idx]   <= dispatch_payload;
         end
      end
   end

endmodule

// File: tb/tb_rs_issue.sv
// Self-checking bench for rs_issue.
// Expected issue order kept in a queue filled at dispatch time.
module tb_rs_issue;

   localparam int RS_SIZE = 8;
   localparam int TAG_W   = 6;
   localparam int PAY_W   = 32;
   localparam int CW      = $clog2(RS_SIZE) + 1;

   logic              clock;
   logic              reset;
   logic              dispatch_valid;
   logic              dispatch_ready;
   logic [TAG_W-1:0]  dispatch_src1;
   logic [TAG_W-1:0]  dispatch_src2;
   logic              dispatch_rdy1;
   logic              dispatch_rdy2;
   logic [TAG_W-1:0]  dispatch_dest;
   logic [PAY_W-1:0]  dispatch_payload;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic              issue_valid;
   logic              issue_ready;
   logic [TAG_W-1:0]  issue_dest;
   logic [PAY_W-1:0]  issue_payload;
   logic [CW-1:0]     free_count;

   typedef struct packed {
      logic [TAG_W-1:0] dest;
      logic [PAY_W-1:0] pay;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks;
   int   n_fail;

   rs_issue #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
      .clock(clock),
      .reset(reset),
      .dispatch_valid(dispatch_valid),
      .dispatch_ready(dispatch_ready),
      .dispatch_src1(dispatch_src1),
      .dispatch_src2(dispatch_src2),
      .dispatch_rdy1(dispatch_rdy1),
      .dispatch_rdy2(dispatch_rdy2),
      .dispatch_dest(dispatch_dest),
      .dispatch_payload(dispatch_payload),
      .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .issue_dest(issue_dest),
      .issue_payload(issue_payload),
      .free_count(free_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dispatch_valid   = 1'b0;
      dispatch_src1    = '0;
      dispatch_src2    = '0;
      dispatch_rdy1    = 1'b0;
      dispatch_rdy2    = 1'b0;
      dispatch_dest    = '0;
      dispatch_payload = '0;
      cdb_valid        = 1'b0;
      cdb_tag          = '0;
      issue_ready      = 1'b0;
   endtask

   task automatic drive_disp(input logic [TAG_W-1:0] s1, input logic r1,
                             input logic [TAG_W-1:0] s2, input logic r2,
                             input logic [TAG_W-1:0] d,
                             input logic [PAY_W-1:0] p);
      dispatch_valid   = 1'b1;
      dispatch_src1    = s1;
      dispatch_rdy1    = r1;
      dispatch_src2    = s2;
      dispatch_rdy2    = r2;
      dispatch_dest    = d;
      dispatch_payload = p;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_checks++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_dready got %0b want 1", dispatch_ready);
      end
      n_checks++;
      if (issue_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ivalid got %0b want 0", issue_valid);
      end
      n_checks++;
      if (issue_dest !== '0 || issue_payload !== '0) begin
         n_fail++;
         $display("FAIL rst_fields got %0h/%0h want 0/0",
                  issue_dest, issue_payload);
      end
      n_checks++;
      if (free_count !== CW'(RS_SIZE)) begin
         n_fail++;
         $display("FAIL rst_free got %0d want %0d", free_count, RS_SIZE);
      end
   endtask

   task automatic test_single();
      drive_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'hA5);
      sb.push_back('{dest: 6'd5, pay: 32'hA5});
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ivalid got %0b want 1", issue_valid);
      end
      e = sb.pop_front();
      n_checks++;
      if (issue_dest !== e.dest || issue_payload !== e.pay) begin
         n_fail++;
         $display("FAIL single_fields got %0d/%0h want %0d/%0h",
                  issue_dest, issue_payload, e.dest, e.pay);
      end
      n_checks++;
      if (free_count !== CW'(7)) begin
         n_fail++;
         $display("FAIL single_free got %0d want 7", free_count);
      end
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      n_checks++;
      if (issue_valid !== 1'b0 || free_count !== CW'(8)) begin
         n_fail++;
         $display("FAIL single_drain got v=%0b f=%0d want v=0 f=8",
                  issue_valid, free_count);
      end
   endtask

   task automatic test_fill_wakeup();
      for (int i = 0; i < RS_SIZE; i++) begin
         drive_disp(6'd9, 1'b0, 6'd3, 1'b1, 6'(10 + i), 32'h100 + i);
         sb.push_back('{dest: 6'(10 + i), pay: 32'h100 + i});
         step();
      end
      idle();
      n_checks++;
      if (dispatch_ready !== 1'b0 || free_count !== '0) begin
         n_fail++;
         $display("FAIL fill_full got r=%0b f=%0d want r=0 f=0",
                  dispatch_ready, free_count);
      end
      n_checks++;
      if (issue_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_noelig got %0b want 0", issue_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 6'd8;
      step();
      cdb_valid = 1'b0;
      n_checks++;
      if (issue_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_wrongtag got %0b want 0", issue_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 6'd9;
      step();
      cdb_valid = 1'b0;
      n_checks++;
      if (issue_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_wake got %0b want 1", issue_valid);
      end
      issue_ready = 1'b1;
      for (int i = 0; i < RS_SIZE; i++) begin
         e = sb.pop_front();
         n_checks++;
         if (issue_valid !== 1'b1 || issue_dest !== e.dest ||
             issue_payload !== e.pay) begin
            n_fail++;
            $display("FAIL fill_issue%0d got v=%0b %0d/%0h want %0d/%0h",
                     i, issue_valid, issue_dest, issue_payload,
                     e.dest, e.pay);
         end
         step();
      end
      issue_ready = 1'b0;
      n_checks++;
      if (issue_valid !== 1'b0 || free_count !== CW'(8)) begin
         n_fail++;
         $display("FAIL fill_empty got v=%0b f=%0d want v=0 f=8",
                  issue_valid, free_count);
      end
   endtask

   task automatic test_bypass();
      drive_disp(6'd4, 1'b1, 6'd12, 1'b0, 6'd33, 32'hBEEF);
      cdb_valid = 1'b1;
      cdb_tag   = 6'd12;
      sb.push_back('{dest: 6'd33, pay: 32'hBEEF});
      step();
      idle();
      e = sb.pop_front();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_dest !== e.dest ||
          issue_payload !== e.pay) begin
         n_fail++;
         $display("FAIL bypass got v=%0b %0d/%0h want 1 %0d/%0h",
                  issue_valid, issue_dest, issue_payload, e.dest, e.pay);
      end
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < RS_SIZE; i++) begin
         drive_disp(6'd1, 1'b1, 6'd1, 1'b1, 6'(20 + i), 32'h200 + i);
         sb.push_back('{dest: 6'(20 + i), pay: 32'h200 + i});
         step();
      end
      idle();
      n_checks++;
      if (dispatch_ready !== 1'b0 || free_count !== '0) begin
         n_fail++;
         $display("FAIL b2b_full got r=%0b f=%0d want r=0 f=0",
                  dispatch_ready, free_count);
      end
      drive_disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd40, 32'h400);
      issue_ready = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (issue_dest !== e.dest || issue_payload !== e.pay) begin
         n_fail++;
         $display("FAIL b2b_first got %0d/%0h want %0d/%0h",
                  issue_dest, issue_payload, e.dest, e.pay);
      end
      step();
      issue_ready = 1'b0;
      n_checks++;
      if (free_count !== CW'(1) || dispatch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_freed got f=%0d r=%0b want f=1 r=1",
                  free_count, dispatch_ready);
      end
      sb.push_front('{dest: 6'd40, pay: 32'h400});
      step();
      idle();
      n_checks++;
      if (free_count !== '0) begin
         n_fail++;
         $display("FAIL b2b_refill got %0d want 0", free_count);
      end
      issue_ready = 1'b1;
      for (int i = 0; i < RS_SIZE; i++) begin
         e = sb.pop_front();
         n_checks++;
         if (issue_valid !== 1'b1 || issue_dest !== e.dest ||
             issue_payload !== e.pay) begin
            n_fail++;
            $display("FAIL b2b_issue%0d got v=%0b %0d/%0h want %0d/%0h",
                     i, issue_valid, issue_dest, issue_payload,
                     e.dest, e.pay);
         end
         step();
      end
      issue_ready = 1'b0;
      n_checks++;
      if (free_count !== CW'(8)) begin
         n_fail++;
         $display("FAIL b2b_empty got %0d want 8", free_count);
      end
   endtask

   task automatic test_hold();
      drive_disp(6'd2, 1'b1, 6'd3, 1'b1, 6'd7, 32'h77);
      sb.push_back('{dest: 6'd7, pay: 32'h77});
      step();
      idle();
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (issue_valid !== 1'b1 || issue_dest !== e.dest ||
             issue_payload !== e.pay || free_count !== CW'(7)) begin
            n_fail++;
            $display("FAIL hold%0d got v=%0b %0d/%0h f=%0d want 1 %0d/%0h 7",
                     i, issue_valid, issue_dest, issue_payload,
                     free_count, e.dest, e.pay);
         end
         step();
      end
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      n_checks++;
      if (free_count !== CW'(8) || issue_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release got f=%0d v=%0b want 8 0",
                  free_count, issue_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         drive_disp(6'd15, 1'b0, 6'd15, 1'b0, 6'(50 + i), 32'h500 + i);
         step();
      end
      idle();
      n_checks++;
      if (free_count !== CW'(4)) begin
         n_fail++;
         $display("FAIL rmid_pre got %0d want 4", free_count);
      end
      drive_disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd60, 32'h600);
      cdb_valid   = 1'b1;
      cdb_tag     = 6'd15;
      issue_ready = 1'b1;
      reset       = 1'b1;
      step();
      reset = 1'b0;
      idle();
      n_checks++;
      if (free_count !== CW'(8) || issue_valid !== 1'b0 ||
          dispatch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_post got f=%0d v=%0b r=%0b want 8 0 1",
                  free_count, issue_valid, dispatch_ready);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 6'd15;
      step();
      idle();
      n_checks++;
      if (issue_valid !== 1'b0 || free_count !== CW'(8)) begin
         n_fail++;
         $display("FAIL rmid_stale got v=%0b f=%0d want 0 8",
                  issue_valid, free_count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle();
      test_reset();
      test_single();
      test_fill_wakeup();
      test_bypass();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover got %0d want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
